// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry
// layout, forwarding-select width helper and the register-file select code.
package pipe_ctrl_pkg;

    localparam int MAX_AW = 8;
    localparam int FWD_RF = 0;

    typedef logic [MAX_AW-1:0] reg_t;

    typedef struct packed {
        logic valid;
        logic wr;
        reg_t dst;
        logic load;
    } entry_t;

    function automatic int sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/src_match.sv
// Youngest-match priority encoder for one source operand against the
// scoreboard stages 1..STAGES-1 (WB is covered by RF write-through).
module src_match
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int SEL_W  = 3
) (
    input  logic                en,
    input  reg_t                src,
    input  entry_t [STAGES-1:1] sb,
    output logic                hit,
    output logic [SEL_W-1:0]    sel,
    output logic                load
);

    // Walk oldest to youngest so the youngest match is written last.
    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        load = 1'b0;
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (en && sb[k].valid && sb[k].wr && sb[k].dst == src) begin
                hit  = 1'b1;
                sel  = SEL_W'(k);
                load = sb[k].load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard unit: stall, flush, forwarding selects,
// retire information and performance counters for the in-order pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 2,
    parameter int STAGES   = 4,
    parameter int BR_STAGE = 2,
    parameter bit FWD_EN   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       dec_valid,
    input  logic                       dec_src1_en,
    input  logic                       dec_src2_en,
    input  logic [REG_AW-1:0]          dec_src1,
    input  logic [REG_AW-1:0]          dec_src2,
    input  logic                       dec_dst_en,
    input  logic [REG_AW-1:0]          dec_dst,
    input  logic                       dec_is_load,
    input  logic                       br_taken,
    input  logic                       cnt_clear,
    output logic                       stall,
    output logic                       issue,
    output logic                       flush,
    output logic [sel_w(STAGES)-1:0]   fwd_sel1,
    output logic [sel_w(STAGES)-1:0]   fwd_sel2,
    output logic [STAGES-1:0]          stage_valid,
    output logic                       retire_valid,
    output logic [REG_AW-1:0]          retire_dst,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt,
    output logic [CNT_W-1:0]           retire_cnt
);

    localparam int SEL_W = sel_w(STAGES);

    entry_t [STAGES:1] sb_q, sb_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, stl_q, stl_d;
    logic [CNT_W-1:0]  fls_q, fls_d, ret_q, ret_d;

    logic             hit1, hit2, ld1, ld2, lu1, lu2, raw;
    logic [SEL_W-1:0] sel1, sel2;

    // Stale IR fields during a bubble must never match.
    src_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_m1 (
        .en   (dec_valid & dec_src1_en),
        .src  (reg_t'(dec_src1)),
        .sb   (sb_q[STAGES-1:1]),
        .hit  (hit1),
        .sel  (sel1),
        .load (ld1)
    );

    src_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_m2 (
        .en   (dec_valid & dec_src2_en),
        .src  (reg_t'(dec_src2)),
        .sb   (sb_q[STAGES-1:1]),
        .hit  (hit2),
        .sel  (sel2),
        .load (ld2)
    );

    always_comb begin
        lu1      = hit1 && (sel1 == SEL_W'(1)) && ld1;
        lu2      = hit2 && (sel2 == SEL_W'(1)) && ld2;
        raw      = FWD_EN ? (lu1 || lu2) : (hit1 || hit2);
        flush    = br_taken;
        stall    = raw && !br_taken;
        issue    = dec_valid && !stall && !flush;
        fwd_sel1 = FWD_EN ? sel1 : SEL_W'(FWD_RF);
        fwd_sel2 = FWD_EN ? sel2 : SEL_W'(FWD_RF);
    end

    always_comb begin
        sb_d = '0;
        if (issue) begin
            sb_d[1] = '{valid: 1'b1, wr: dec_dst_en,
                        dst: reg_t'(dec_dst), load: dec_is_load};
        end
        for (int k = 2; k <= STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
            if (br_taken && (k - 1) < BR_STAGE) sb_d[k] = '0;
        end
    end

    always_comb begin
        cyc_d = cnt_clear ? '0 : cyc_q + CNT_W'(1);
        stl_d = cnt_clear ? '0 : stl_q + CNT_W'(stall);
        fls_d = cnt_clear ? '0 : fls_q + CNT_W'(flush);
        ret_d = cnt_clear ? '0 : ret_q + CNT_W'(sb_q[STAGES].valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_q  <= '0;
            cyc_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
            ret_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cyc_q <= cyc_d;
            stl_q <= stl_d;
            fls_q <= fls_d;
            ret_q <= ret_d;
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 1; k <= STAGES; k++) stage_valid[k-1] = sb_q[k].valid;
    end

    logic unused_bits;
    assign unused_bits = ^{sb_q[STAGES].load, sb_q[STAGES].dst};

    assign retire_valid = sb_q[STAGES].valid & sb_q[STAGES].wr;
    assign retire_dst   = sb_q[STAGES].dst[REG_AW-1:0];
    assign cycle_cnt    = cyc_q;
    assign stall_cnt    = stl_q;
    assign flush_cnt    = fls_q;
    assign retire_cnt   = ret_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, no-forwarding and
// 4-bit-counter instances share one stimulus stream.
module tb_pipe_hazard_ctrl;

    logic       clock, reset;
    logic       dec_valid, dec_src1_en, dec_src2_en;
    logic [1:0] dec_src1, dec_src2, dec_dst;
    logic       dec_dst_en, dec_is_load, br_taken, cnt_clear;

    logic        f_stall, f_issue, f_flush, f_rv;
    logic [2:0]  f_f1, f_f2;
    logic [3:0]  f_sv;
    logic [1:0]  f_rd;
    logic [15:0] f_cyc, f_stc, f_flc, f_rtc;

    logic        n_stall, n_issue, n_flush, n_rv;
    logic [2:0]  n_f1, n_f2;
    logic [3:0]  n_sv;
    logic [1:0]  n_rd;
    logic [15:0] n_cyc, n_stc, n_flc, n_rtc;

    logic        c_stall, c_issue, c_flush, c_rv;
    logic [2:0]  c_f1, c_f2;
    logic [3:0]  c_sv;
    logic [1:0]  c_rd;
    logic [3:0]  c_cyc, c_stc, c_flc, c_rtc;

    int n_err = 0;
    int n_chk = 0;

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clock(clock), .reset(reset), .dec_valid(dec_valid),
        .dec_src1_en(dec_src1_en), .dec_src2_en(dec_src2_en),
        .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_dst_en(dec_dst_en), .dec_dst(dec_dst),
        .dec_is_load(dec_is_load), .br_taken(br_taken),
        .cnt_clear(cnt_clear), .stall(f_stall), .issue(f_issue),
        .flush(f_flush), .fwd_sel1(f_f1), .fwd_sel2(f_f2),
        .stage_valid(f_sv), .retire_valid(f_rv), .retire_dst(f_rd),
        .cycle_cnt(f_cyc), .stall_cnt(f_stc), .flush_cnt(f_flc),
        .retire_cnt(f_rtc)
    );

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) u_nof (
        .clock(clock), .reset(reset), .dec_valid(dec_valid),
        .dec_src1_en(dec_src1_en), .dec_src2_en(dec_src2_en),
        .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_dst_en(dec_dst_en), .dec_dst(dec_dst),
        .dec_is_load(dec_is_load), .br_taken(br_taken),
        .cnt_clear(cnt_clear), .stall(n_stall), .issue(n_issue),
        .flush(n_flush), .fwd_sel1(n_f1), .fwd_sel2(n_f2),
        .stage_valid(n_sv), .retire_valid(n_rv), .retire_dst(n_rd),
        .cycle_cnt(n_cyc), .stall_cnt(n_stc), .flush_cnt(n_flc),
        .retire_cnt(n_rtc)
    );

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(4)) u_c4 (
        .clock(clock), .reset(reset), .dec_valid(dec_valid),
        .dec_src1_en(dec_src1_en), .dec_src2_en(dec_src2_en),
        .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_dst_en(dec_dst_en), .dec_dst(dec_dst),
        .dec_is_load(dec_is_load), .br_taken(br_taken),
        .cnt_clear(cnt_clear), .stall(c_stall), .issue(c_issue),
        .flush(c_flush), .fwd_sel1(c_f1), .fwd_sel2(c_f2),
        .stage_valid(c_sv), .retire_valid(c_rv), .retire_dst(c_rd),
        .cycle_cnt(c_cyc), .stall_cnt(c_stc), .flush_cnt(c_flc),
        .retire_cnt(c_rtc)
    );

    typedef struct {
        int v, s1e, s1, s2e, s2, de, d, ld, br;
        int st, is, fl, cf, f1, f2, sv, rv, rd;
    } vec_t;

    vec_t tbl[8];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        dec_valid   = 1'b0;
        dec_src1_en = 1'b0;
        dec_src2_en = 1'b0;
        dec_src1    = 2'd0;
        dec_src2    = 2'd0;
        dec_dst_en  = 1'b0;
        dec_dst     = 2'd0;
        dec_is_load = 1'b0;
        br_taken    = 1'b0;
        cnt_clear   = 1'b0;
    endtask

    task automatic drive(input int v, input int s1e, input int s1,
                         input int s2e, input int s2, input int de,
                         input int d, input int ld, input int br);
        dec_valid   = 1'(v);
        dec_src1_en = 1'(s1e);
        dec_src1    = 2'(s1);
        dec_src2_en = 1'(s2e);
        dec_src2    = 2'(s2);
        dec_dst_en  = 1'(de);
        dec_dst     = 2'(d);
        dec_is_load = 1'(ld);
        br_taken    = 1'(br);
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;

        // Reset state; issue follows dec_valid even while in reset.
        @(negedge clock);
        @(negedge clock);
        dec_valid = 1'b1;
        #1;
        chk("rst_issue", 32'(f_issue), 1);
        chk("rst_stall", 32'(f_stall), 0);
        chk("rst_flush", 32'(f_flush), 0);
        chk("rst_sv", 32'(f_sv), 0);
        chk("rst_rv", 32'(f_rv), 0);
        chk("rst_rd", 32'(f_rd), 0);
        chk("rst_fsel", 32'({f_f1, f_f2}), 0);
        chk("rst_cnts", 32'({f_cyc, f_stc, f_flc, f_rtc}), 0);

        // Forwarding, load-use and stale-IR vectors on the FWD_EN=1 unit.
        //            v s1e s1 s2e s2 de d ld br  st is fl cf f1 f2 sv   rv rd
        tbl[0] = '{1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 1, 0, 0, 4'b0000, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 1, 2, 0, 0,   0, 1, 0, 1, 1, 0, 4'b0001, 0, 0};
        tbl[2] = '{1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 2, 0, 4'b0011, 0, 0};
        tbl[3] = '{1, 0, 0, 0, 0, 1, 3, 1, 0,   0, 1, 0, 1, 0, 0, 4'b0111, 0, 0};
        tbl[4] = '{1, 1, 2, 1, 3, 1, 0, 1, 0,   1, 0, 0, 0, 0, 0, 4'b1111, 1, 1};
        tbl[5] = '{1, 1, 2, 1, 3, 1, 0, 1, 0,   0, 1, 0, 1, 0, 2, 4'b1110, 1, 2};
        tbl[6] = '{0, 1, 0, 1, 0, 1, 1, 0, 0,   0, 0, 0, 1, 0, 0, 4'b1101, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 4'b1010, 1, 3};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].s1e, tbl[i].s1, tbl[i].s2e, tbl[i].s2,
                  tbl[i].de, tbl[i].d, tbl[i].ld, tbl[i].br);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(f_stall), tbl[i].st);
            chk($sformatf("v%0d_issue", i), 32'(f_issue), tbl[i].is);
            chk($sformatf("v%0d_flush", i), 32'(f_flush), tbl[i].fl);
            chk($sformatf("v%0d_sv", i), 32'(f_sv), tbl[i].sv);
            chk($sformatf("v%0d_rv", i), 32'(f_rv), tbl[i].rv);
            if (tbl[i].rv != 0)
                chk($sformatf("v%0d_rd", i), 32'(f_rd), tbl[i].rd);
            if (tbl[i].cf != 0) begin
                chk($sformatf("v%0d_f1", i), 32'(f_f1), tbl[i].f1);
                chk($sformatf("v%0d_f2", i), 32'(f_f2), tbl[i].f2);
            end
            @(negedge clock);
        end
        idle();
        #1;
        chk("tbl_stall_cnt", 32'(f_stc), 1);
        chk("tbl_retire_cnt", 32'(f_rtc), 4);
        chk("tbl_cycle_cnt", 32'(f_cyc), 8);
        chk("tbl_flush_cnt", 32'(f_flc), 0);

        // No forwarding: stall held while r1 sits in stages 1..3.
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        #1;
        chk("nof_issue0", 32'(n_issue), 1);
        @(negedge clock);
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 1, 1, 0, 1, 2, 0, 0);
            #1;
            chk($sformatf("nof_stall%0d", c), 32'(n_stall), (c < 3) ? 1 : 0);
            chk($sformatf("nof_issue%0d", c), 32'(n_issue), (c == 3) ? 1 : 0);
            chk($sformatf("nof_fsel%0d", c), 32'(n_f1), 0);
            @(negedge clock);
        end
        idle();
        #1;
        chk("nof_stall_cnt", 32'(n_stc), 3);

        // Branch flush overrides a load-use stall; stage 2 survives.
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        @(negedge clock);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        @(negedge clock);
        drive(1, 1, 1, 0, 0, 1, 2, 0, 1);
        #1;
        chk("br_flush", 32'(f_flush), 1);
        chk("br_stall", 32'(f_stall), 0);
        chk("br_issue", 32'(f_issue), 0);
        chk("br_sv_pre", 32'(f_sv), 4'b0011);
        @(negedge clock);
        idle();
        #1;
        chk("br_sv_post", 32'(f_sv), 4'b0100);
        chk("br_flush_cnt", 32'(f_flc), 1);
        chk("br_stall_cnt", 32'(f_stc), 0);

        // Six writes retire in order four cycles after issue.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i < 6) drive(1, 0, 0, 0, 0, 1, i % 4, 0, 0);
            else idle();
            #1;
            chk($sformatf("ret_rv%0d", i), 32'(f_rv),
                (i >= 4 && i <= 9) ? 1 : 0);
            if (i >= 4 && i <= 9)
                chk($sformatf("ret_rd%0d", i), 32'(f_rd), (i - 4) % 4);
            if (i == 10) chk("ret_cnt", 32'(f_rtc), 6);
            @(negedge clock);
        end

        // 4-bit counters: wrap, clear against a stall, mid-stream reset.
        do_reset();
        #1;
        chk("c4_cyc0", 32'(c_cyc), 0);
        repeat (17) @(negedge clock);
        #1;
        chk("c4_wrap", 32'(c_cyc), 1);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        @(negedge clock);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("c4_lu1", 32'(c_stall), 1);
        @(negedge clock);
        drive(1, 1, 1, 0, 0, 1, 2, 1, 0);
        #1;
        chk("c4_stc1", 32'(c_stc), 1);
        chk("c4_nostall", 32'(c_stall), 0);
        chk("c4_fsel2", 32'(c_f1), 2);
        @(negedge clock);
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0);
        cnt_clear = 1'b1;
        #1;
        chk("c4_lu2", 32'(c_stall), 1);
        @(negedge clock);
        cnt_clear = 1'b0;
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0);
        #1;
        chk("c4_clr_stc", 32'(c_stc), 0);
        chk("c4_clr_cyc", 32'(c_cyc), 0);
        @(negedge clock);
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("c4_lu3", 32'(c_stall), 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("c4_rst_sv", 32'(c_sv), 0);
        chk("c4_rst_cnts", 32'({c_cyc, c_stc, c_flc, c_rtc}), 0);
        chk("c4_rst_stall", 32'(c_stall), 0);
        chk("c4_rst_issue", 32'(c_issue), 1);
        @(negedge clock);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
